// File: rtl/window_discriminator_n.sv
// ---------------------------------------------------------------------------
// window_discriminator_n
//
// Multi-window spike discriminator for one DAC channel. It sits after the
// HPF/threshold stage. A trigger crossing opens a post-trigger sample count.
// While the count runs, every sample is checked against NUM_WIN amplitude
// windows. Each window has its own index range, threshold, polarity and
// inclusion/exclusion type. Once the sample at index stop_max has been
// processed, the block spends one DECIDE cycle and then emits a one-cycle
// accept pulse on detect if every window agreed.
//
// Samples and thresholds are offset-binary (32768 = 0 uV), so every
// amplitude compare is a plain unsigned compare.
//
// Parameters
//   DATA_W   sample / threshold width
//   NUM_WIN  number of windows (1..8)
//   CNT_W    post-trigger sample counter width
//
// Ports
//   dataclk       system clock; all state changes on the rising edge
//   reset         synchronous, active-high; wins over every other input
//   enable        0 forces IDLE, clears hits and index, suppresses detect
//   sample_valid  one-cycle strobe per new sample
//   sample_in     filtered amplifier sample
//   trig_thrsh    trigger threshold
//   trig_pol      1: crossing when sample >= thrsh, 0: when sample <= thrsh
//   win_start     window k first index, bits [k*CNT_W +: CNT_W]
//   win_stop      window k last index (inclusive)
//   win_thrsh     window k threshold, bits [k*DATA_W +: DATA_W]
//   win_pol       window k polarity, same rule as trig_pol
//   win_type      0: inclusion (must hit), 1: exclusion (must not hit)
//   stop_max      last post-trigger index that is evaluated
//   detect        one-cycle accept pulse
//   busy          high while in ARMED or DECIDE
//   fsm_state     00 IDLE, 01 ARMED, 10 DECIDE
//   sample_idx    current post-trigger index
//   win_hit       sticky per-window hit flags for the current event
//
// The configuration inputs must stay static while busy is high.
// ---------------------------------------------------------------------------
module window_discriminator_n #(
    parameter int DATA_W  = 16,
    parameter int NUM_WIN = 2,
    parameter int CNT_W   = 8
) (
    input  logic                       dataclk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       sample_valid,
    input  logic [DATA_W-1:0]          sample_in,
    input  logic [DATA_W-1:0]          trig_thrsh,
    input  logic                       trig_pol,
    input  logic [NUM_WIN*CNT_W-1:0]   win_start,
    input  logic [NUM_WIN*CNT_W-1:0]   win_stop,
    input  logic [NUM_WIN*DATA_W-1:0]  win_thrsh,
    input  logic [NUM_WIN-1:0]         win_pol,
    input  logic [NUM_WIN-1:0]         win_type,
    input  logic [CNT_W-1:0]           stop_max,
    output logic                       detect,
    output logic                       busy,
    output logic [1:0]                 fsm_state,
    output logic [CNT_W-1:0]           sample_idx,
    output logic [NUM_WIN-1:0]         win_hit
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ARMED  = 2'b01,
        ST_DECIDE = 2'b10
    } state_e;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e               state_q,  state_d;
    logic [CNT_W-1:0]     idx_q,    idx_d;
    logic [NUM_WIN-1:0]   hit_q,    hit_d;
    logic                 detect_q, detect_d;
    logic                 busy_q,   busy_d;

    // -----------------------------------------------------------------------
    // Combinational datapath
    // -----------------------------------------------------------------------
    logic                 trig_cross;
    logic                 idx_sat;
    logic [CNT_W-1:0]     eval_idx;
    logic                 eval_last;
    logic [NUM_WIN-1:0]   win_in_range;
    logic [NUM_WIN-1:0]   win_cross;
    logic [NUM_WIN-1:0]   win_set;
    logic                 all_pass;

    assign trig_cross = trig_pol ? (sample_in >= trig_thrsh)
                                 : (sample_in <= trig_thrsh);

    // Index that the current edge would store. The trigger sample is index 0;
    // in ARMED each strobe advances by one. Saturating the increment keeps
    // the counter from wrapping even if stop_max is the all-ones value.
    assign idx_sat   = &idx_q;
    assign eval_idx  = (state_q == ST_IDLE) ? '0
                     : (idx_sat ? idx_q : idx_q + CNT_W'(1));

    // Under static configuration this only ever fires on equality; using >=
    // also guarantees termination if the index somehow passed stop_max.
    assign eval_last = (eval_idx >= stop_max);

    // Per-window comparators, purely combinational on the current inputs.
    // A window whose start is above its stop can never be in range.
    for (genvar k = 0; k < NUM_WIN; k++) begin : g_win
        logic [CNT_W-1:0]  start_k;
        logic [CNT_W-1:0]  stop_k;
        logic [DATA_W-1:0] thr_k;

        assign start_k = win_start[k*CNT_W +: CNT_W];
        assign stop_k  = win_stop[k*CNT_W +: CNT_W];
        assign thr_k   = win_thrsh[k*DATA_W +: DATA_W];

        assign win_in_range[k] = (eval_idx >= start_k) && (eval_idx <= stop_k);
        assign win_cross[k]    = win_pol[k] ? (sample_in >= thr_k)
                                            : (sample_in <= thr_k);
        assign win_set[k]      = win_in_range[k] & win_cross[k];
    end

    // Inclusion windows pass when hit, exclusion windows pass when not hit.
    assign all_pass = &(hit_q ^ win_type);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        idx_d    = idx_q;
        hit_d    = hit_q;
        detect_d = 1'b0;

        if (!enable) begin
            // Disable drops any event in progress, including a pending decision.
            state_d = ST_IDLE;
            idx_d   = '0;
            hit_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (sample_valid && trig_cross) begin
                        // The trigger sample is itself checked against the windows.
                        idx_d   = '0;
                        hit_d   = win_set;
                        state_d = eval_last ? ST_DECIDE : ST_ARMED;
                    end
                end

                ST_ARMED: begin
                    // Without a strobe, index and hits hold; there is no timeout.
                    if (sample_valid) begin
                        idx_d = eval_idx;
                        hit_d = hit_q | win_set;
                        if (eval_last) begin
                            state_d = ST_DECIDE;
                        end
                    end
                end

                ST_DECIDE: begin
                    // Strobes here are ignored; no retrigger until back in IDLE.
                    detect_d = all_pass;
                    state_d  = ST_IDLE;
                    idx_d    = '0;
                    hit_d    = '0;
                end

                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    hit_d   = '0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge dataclk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            hit_q    <= '0;
            detect_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            hit_q    <= hit_d;
            detect_q <= detect_d;
            busy_q   <= busy_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign detect     = detect_q;
    assign busy       = busy_q;
    assign fsm_state  = state_q;
    assign sample_idx = idx_q;
    assign win_hit    = hit_q;

endmodule
